systolic_skewer: RTL

SYSTOLIC_SKEWER -- requirements
Module: systolic_skewer

---
 rtl/systolic_skewer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/systolic_skewer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skewer
// Brief    : Per-lane delay-line array that skews (lane i delayed i beats) or
//            deskews (lane i delayed LANES-1-i beats) a row of lane words.
//            A small IDLE/RUN/DRAIN FSM tracks occupancy and pulses done once
//            the last valid row has left every lane.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skewer #(
  parameter int DATA_W = 32,
  parameter int LANES  = 16,
  parameter int MODE   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [LANES-1:0][DATA_W-1:0]   data_in,
  output logic [LANES-1:0][DATA_W-1:0]   data_out,
  output logic [LANES-1:0]               out_valid,
  output logic                           busy,
  output logic                           done
);

  localparam int                DMAX   = LANES - 1;
  localparam int                CNT_W  = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0]  C_DMAX = CNT_W'(DMAX);
  localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_busy;
  logic               w_done;
  logic               w_beat;

  // A beat that actually moves data; flush overrides en.
  assign w_beat = en & ~flush;

  // --------------------------------------------------------------------------
  // Lane delay lines
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int D = (MODE == 0) ? gi : (LANES - 1 - gi);

    if (D == 0) begin : g_pass
      assign data_out[gi]  = data_in[gi];
      assign out_valid[gi] = in_valid & w_beat;
    end else begin : g_chain
      logic [DATA_W-1:0] r_data [D];
      logic [D-1:0]      r_vld;

      // Shift data and valid one stage per beat; flush drops valids but keeps data.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < D; k++) r_data[k] <= '0;
          r_vld <= '0;
        end else if (flush) begin
          r_vld <= '0;
        end else if (en) begin
          r_data[0] <= data_in[gi];
          r_vld[0]  <= in_valid;
          for (int k = 1; k < D; k++) begin
            r_data[k] <= r_data[k-1];
            r_vld[k]  <= r_vld[k-1];
          end
        end
      end

      assign data_out[gi]  = r_data[D-1];
      assign out_valid[gi] = r_vld[D-1] & w_beat;
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy FSM
  // --------------------------------------------------------------------------

  // Next-state / counter / done: a valid beat (re)arms the drain count to the
  // longest lane delay; each empty beat counts down, and an empty beat with the
  // count already at zero means the deepest lane has emitted its last row.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (en) begin
      if (in_valid) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = C_DMAX;
      end else if (r_state != S_IDLE) begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = r_cnt - C_ONE;
        end
      end
    end
  end

  // State, drain counter and registered busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign busy = r_busy;
  assign done = w_done;

endmodule
`default_nettype wire
